// File: rtl/jk_pkg.sv
// jk_pkg: shared JK flip-flop encodings and the excitation helper used by
// jk_mod_counter and jk_ff.
//   JK_HOLD/JK_RST/JK_SET/JK_TOG : {j,k} codes
//   jk_excite(n, q)              : minimal {j,k} to move one flop from q to n
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Unchanged bits get HOLD; a changing bit gets SET or RST, so the toggle
  // code is never produced.
  function automatic logic [1:0] jk_excite(input logic n, input logic q);
    return {n & ~q, q & ~n};
  endfunction

endpackage

// File: rtl/jk_ff.sv
// jk_ff: single JK flip-flop with synchronous active-high reset.
//   clk : clock, state updates on posedge
//   rst : synchronous reset, forces q to 0
//   j,k : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q   : flop output
//   qb  : complement of q
module jk_ff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TOG:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter whose state lives in a bank
// of WIDTH jk_ff flops. This block computes the next count, drives each
// flop's j/k with the minimal excitation, and flags terminal count / wrap.
//   clk      : clock
//   rst      : synchronous active-high reset (also resets every jk_ff)
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : synchronous parallel load of din (priority over en)
//   din      : load value; values >= MODULUS clamp to MODULUS-1
//   q        : current count
//   tc       : combinational terminal count, gated by en
//   wrap     : registered one-cycle pulse after a wrapping edge
//   load_err : registered one-cycle pulse after a clamped load
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] qb_bank;
  logic [WIDTH-1:0] j_bus;
  logic [WIDTH-1:0] k_bus;
  logic [WIDTH-1:0] next_cnt;

  // Arithmetic carries an extra bit so q+1 at 2**WIDTH-1 does not alias to 0
  // and a borrow from 0 is visible in the MSB.
  logic [WIDTH:0] q_inc_ext;
  logic [WIDTH:0] q_dec_ext;
  logic [WIDTH:0] din_ext;

  logic wrap_q, wrap_d;
  logic load_err_q, load_err_d;

  assign q_inc_ext = {1'b0, q_bank} + (WIDTH+1)'(1);
  assign q_dec_ext = {1'b0, q_bank} - (WIDTH+1)'(1);
  assign din_ext   = {1'b0, din};

  always_comb begin
    next_cnt   = q_bank;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (din_ext < MOD_EXT) begin
        next_cnt = din;
      end else begin
        next_cnt   = MOD_LAST;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q_inc_ext == MOD_EXT) begin
          next_cnt = '0;
          wrap_d   = 1'b1;
        end else begin
          next_cnt = q_inc_ext[WIDTH-1:0];
        end
      end else begin
        if (q_dec_ext[WIDTH]) begin
          next_cnt = MOD_LAST;
          wrap_d   = 1'b1;
        end else begin
          next_cnt = q_dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Reset reaches the flops directly, so the excitation need not see rst.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j_bus[i], k_bus[i]} = jk_excite(next_cnt[i], q_bank[i]);

    jk_ff u_jk_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_bus[i]),
      .k   (k_bus[i]),
      .q   (q_bank[i]),
      .qb  (qb_bank[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // All-ones on the complement outputs is the zero count.
  assign tc       = en & (up ? (q_bank == MOD_LAST) : (&qb_bank));
  assign q        = q_bank;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_exp [5]  = '{2, 1, 0, 9, 8};

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_tc", tc, 0);

    // Up count through one wrap
    en = 1'b1; up = 1'b1;
    #1;
    chk("up_tc_at0", tc, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", q, up_exp[i]);
      chk("up_wrap", wrap, (i == 9) ? 1 : 0);
      chk("up_tc", tc, (up_exp[i] == 9) ? 1 : 0);
    end

    // Load 3 then count down through a wrap
    en = 1'b0; load = 1'b1; din = 4'd3;
    tick();
    chk("ld3_q", q, 3);
    chk("ld3_wrap", wrap, 0);
    chk("ld3_load_err", load_err, 0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dn_q", q, dn_exp[i]);
      chk("dn_wrap", wrap, (i == 3) ? 1 : 0);
      chk("dn_tc", tc, (dn_exp[i] == 0) ? 1 : 0);
    end

    // Out-of-range loads clamp to 9
    en = 1'b0; load = 1'b1; din = 4'd12;
    tick();
    chk("ld12_q", q, 9);
    chk("ld12_load_err", load_err, 1);
    load = 1'b0;
    tick();
    chk("ld12_q_hold", q, 9);
    chk("ld12_err_drop", load_err, 0);
    load = 1'b1; din = 4'd10;
    tick();
    chk("ld10_q", q, 9);
    chk("ld10_load_err", load_err, 1);
    din = 4'd9;
    tick();
    chk("ld9_q", q, 9);
    chk("ld9_load_err", load_err, 0);
    din = 4'd0;
    tick();
    chk("ld0_q", q, 0);
    chk("ld0_load_err", load_err, 0);

    // Load beats a wrapping count in the same cycle
    din = 4'd9;
    tick();
    en = 1'b1; up = 1'b1; din = 4'd5;
    #1;
    chk("pri_tc_at9", tc, 1);
    tick();
    chk("pri_q", q, 5);
    chk("pri_wrap", wrap, 0);

    // Reset beats a concurrent clamped load while counting at 7
    load = 1'b0;
    tick();
    tick();
    chk("pre_rst_q", q, 7);
    rst = 1'b1; load = 1'b1; din = 4'd12;
    tick();
    chk("rst2_q", q, 0);
    chk("rst2_wrap", wrap, 0);
    chk("rst2_load_err", load_err, 0);
    rst = 1'b0;

    // Hold at 6
    en = 1'b0; din = 4'd6;
    tick();
    chk("hold_ld_q", q, 6);
    load = 1'b0; up = 1'b1;
    #1;
    chk("hold_j", dut.j_bus, 0);
    chk("hold_k", dut.k_bus, 0);
    chk("hold_tc", tc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_q", q, 6);
      chk("hold_jk", {dut.j_bus, dut.k_bus}, 0);
    end

    // Excitation 7 -> 8 and 8 -> 7
    load = 1'b1; din = 4'd7;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    chk("exc_up_j", dut.j_bus, 4'b1000);
    chk("exc_up_k", dut.k_bus, 4'b0111);
    tick();
    chk("exc_up_q", q, 8);
    up = 1'b0;
    #1;
    chk("exc_dn_j", dut.j_bus, 4'b0111);
    chk("exc_dn_k", dut.k_bus, 4'b1000);
    en = 1'b0;
    tick();
    chk("exc_hold_q", q, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
